// File: rtl/ysyx_22041752_booth_mul_seq.sv
// Iterative radix-4 Booth multiplier for the EX stage: one Booth digit per cycle,
// XLEN/2+1 accumulates per operation, RV64M MUL/MULH/MULHSU/MULHU/MULW result select.
module ysyx_22041752_booth_mul_seq #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [1:0]      mul_op,
  input  logic            is_word,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int PW = 2 * XLEN;
  localparam int YW = XLEN + 3;
  localparam int CW = $clog2(XLEN / 2 + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(XLEN / 2);

  localparam logic [1:0] OP_MUL    = 2'd0;
  localparam logic [1:0] OP_MULH   = 2'd1;
  localparam logic [1:0] OP_MULHSU = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             word_q, word_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic             in_ready_q, busy_q, out_valid_q;

  logic [PW:0]      pp_s;
  logic [PW-1:0]    acc_sum_s;
  logic             x_sign_s;
  logic             y_sign_s;

  // Radix-4 Booth partial product generator; returns {carry_in, partial_product}.
  // Negative digits are formed as one's complement plus a carry of 1.
  function automatic logic [PW:0] booth_pp(input logic [PW-1:0] x, input logic [2:0] win);
    logic [PW-1:0] p;
    logic          c;
    case (win)
      3'b001, 3'b010: begin p = x;                 c = 1'b0; end
      3'b011:         begin p = {x[PW-2:0], 1'b0}; c = 1'b0; end
      3'b100:         begin p = ~{x[PW-2:0], 1'b0}; c = 1'b1; end
      3'b101, 3'b110: begin p = ~x;                c = 1'b1; end
      default:        begin p = {PW{1'b0}};        c = 1'b0; end
    endcase
    return {c, p};
  endfunction

  function automatic logic [XLEN-1:0] sel_result(input logic [PW-1:0] p,
                                                 input logic [1:0]    op,
                                                 input logic          w);
    logic [XLEN-1:0] r;
    if (w) begin
      r = {{(XLEN-32){p[31]}}, p[31:0]};
    end else if (op == OP_MUL) begin
      r = p[XLEN-1:0];
    end else begin
      r = p[PW-1:XLEN];
    end
    return r;
  endfunction

  assign pp_s      = booth_pp(x_q, y_q[2:0]);
  assign acc_sum_s = acc_q + pp_s[PW-1:0] + {{(PW-1){1'b0}}, pp_s[PW]};
  assign x_sign_s  = src1[XLEN-1] & ((mul_op == OP_MULH) | (mul_op == OP_MULHSU));
  assign y_sign_s  = src2[XLEN-1] & (mul_op == OP_MULH);

  // Next-state, datapath update and result capture; flush overrides every state.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    word_d   = word_q;
    result_d = result_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            state_d = S_BUSY;
            x_d     = {{XLEN{x_sign_s}}, src1};
            y_d     = {{2{y_sign_s}}, src2, 1'b0};
            acc_d   = {PW{1'b0}};
            cnt_d   = CNT_INIT;
            op_d    = mul_op;
            word_d  = is_word;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_BUSY: begin
          acc_d = acc_sum_s;
          x_d   = {x_q[PW-3:0], 2'b00};
          y_d   = {{2{y_q[YW-1]}}, y_q[YW-1:2]};
          if (cnt_q == {CW{1'b0}}) begin
            state_d  = S_DONE;
            cnt_d    = {CW{1'b0}};
            result_d = sel_result(acc_sum_s, op_q, word_q);
          end else begin
            state_d = S_BUSY;
            cnt_d   = cnt_q - CW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      x_q         <= {PW{1'b0}};
      y_q         <= {YW{1'b0}};
      acc_q       <= {PW{1'b0}};
      cnt_q       <= {CW{1'b0}};
      op_q        <= 2'b00;
      word_q      <= 1'b0;
      result_q    <= {XLEN{1'b0}};
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      word_q      <= word_d;
      result_q    <= result_d;
      in_ready_q  <= (state_d == S_IDLE);
      busy_q      <= (state_d != S_IDLE);
      out_valid_q <= (state_d == S_DONE);
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule

// File: tb/tb_ysyx_22041752_booth_mul_seq.sv
// Self-checking bench for the sequential Booth multiplier: reset, corner operands,
// latency, backpressure, flush/reset aborts and random ops against a scoreboard.
module tb_ysyx_22041752_booth_mul_seq;

  localparam int LAT = 34;
  localparam int TIMEOUT = 200;

  logic        clk = 1'b0;
  logic        resetn, flush, in_valid, in_ready, is_word, busy, out_valid, out_ready;
  logic [63:0] src1, src2, result;
  logic [1:0]  mul_op;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  ysyx_22041752_booth_mul_seq #(.XLEN(64)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .src1(src1), .src2(src2), .mul_op(mul_op), .is_word(is_word), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic [1:0] op, input logic w);
    logic [127:0] xa, yb, p;
    if (w) begin
      p = {64'd0, a} * {64'd0, b};
      return {{32{p[31]}}, p[31:0]};
    end
    xa = (op == 2'd1 || op == 2'd2) ? {{64{a[63]}}, a} : {64'd0, a};
    yb = (op == 2'd1) ? {{64{b[63]}}, b} : {64'd0, b};
    p  = xa * yb;
    return (op == 2'd0) ? p[63:0] : p[127:64];
  endfunction

  // Presents one request for a single cycle while in IDLE, then scrambles the inputs.
  task automatic start_op(input logic [63:0] a, input logic [63:0] b,
                          input logic [1:0] op, input logic w);
    src1 = a; src2 = b; mul_op = op; is_word = w; in_valid = 1'b1;
    exp_q.push_back(model(a, b, op, w));
    @(posedge clk); #1;
    in_valid = 1'b0;
    src1 = {$urandom, $urandom}; src2 = {$urandom, $urandom};
    mul_op = 2'($urandom); is_word = 1'($urandom);
  endtask

  // Counts cycles from the request cycle (cycle 0) until out_valid shows up.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!out_valid && lat < TIMEOUT) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({in_ready, busy, out_valid} !== 3'b100 || result !== 64'd0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy/busy/vld=%b result=%h expected 100 result=0",
               {in_ready, busy, out_valid}, result);
    end
  endtask

  task automatic test_mul_basic();
    int lat;
    logic [63:0] e;
    out_ready = 1'b1;
    start_op(64'd3, 64'd5, 2'd0, 1'b0);
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL accept_state: got in_ready=%b busy=%b expected 0 1", in_ready, busy);
    end
    wait_done(lat);
    checks++;
    if (lat !== LAT || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL mul_latency: got %0d (valid=%b) expected %0d", lat, out_valid, LAT);
    end
    e = exp_q.pop_front();
    checks++;
    if (result !== 64'd15 || result !== e) begin
      errors++;
      $display("FAIL mul_3x5: got %h expected %h", result, 64'd15);
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL after_handshake: got in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_corners();
    logic [63:0] ta[5], tb[5], te[5];
    logic [1:0]  top[5];
    logic [63:0] e;
    int lat;
    ta[0] = 64'hFFFF_FFFF_FFFF_FFFF; tb[0] = 64'hFFFF_FFFF_FFFF_FFFF; top[0] = 2'd1; te[0] = 64'd0;
    ta[1] = 64'hFFFF_FFFF_FFFF_FFFF; tb[1] = 64'hFFFF_FFFF_FFFF_FFFF; top[1] = 2'd3; te[1] = 64'hFFFF_FFFF_FFFF_FFFE;
    ta[2] = 64'hFFFF_FFFF_FFFF_FFFF; tb[2] = 64'd2;                   top[2] = 2'd2; te[2] = 64'hFFFF_FFFF_FFFF_FFFF;
    ta[3] = 64'h8000_0000_0000_0000; tb[3] = 64'hFFFF_FFFF_FFFF_FFFF; top[3] = 2'd1; te[3] = 64'd0;
    ta[4] = 64'hFFFF_FFFF_FFFF_FFFF; tb[4] = 64'h8000_0000_0000_0000; top[4] = 2'd3; te[4] = 64'h7FFF_FFFF_FFFF_FFFF;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      start_op(ta[i], tb[i], top[i], 1'b0);
      wait_done(lat);
      e = exp_q.pop_front();
      checks++;
      if (lat !== LAT || result !== te[i] || result !== e) begin
        errors++;
        $display("FAIL corner_%0d: got result=%h lat=%0d expected result=%h lat=%0d",
                 i, result, lat, te[i], LAT);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [63:0] e;
    out_ready = 1'b0;
    start_op(64'h7FFF_FFFF, 64'd2, 2'd3, 1'b1);
    wait_done(lat);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 64'hFFFF_FFFF_FFFF_FFFE) begin
        errors++;
        $display("FAIL backpressure_hold_%0d: got valid=%b in_ready=%b result=%h expected 1 0 %h",
                 i, out_valid, in_ready, result, 64'hFFFF_FFFF_FFFF_FFFE);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (result !== e) begin
      errors++;
      $display("FAIL mulw_result: got %h expected %h", result, e);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release: got rdy=%b vld=%b busy=%b expected 1 0 0", in_ready, out_valid, busy);
    end
  endtask

  task automatic test_flush();
    int lat;
    logic [63:0] e;
    out_ready = 1'b1;
    // Flush in IDLE blocks the request.
    src1 = 64'd9; src2 = 64'd9; mul_op = 2'd0; is_word = 1'b0; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_idle: got busy=%b in_ready=%b expected 0 1", busy, in_ready);
    end
    // Flush in BUSY cycle 10, then an immediate new request.
    start_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 2'd0, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    void'(exp_q.pop_back());
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_busy: got busy=%b rdy=%b vld=%b expected 0 1 0", busy, in_ready, out_valid);
    end
    start_op(64'd7, 64'd6, 2'd0, 1'b0);
    wait_done(lat);
    e = exp_q.pop_front();
    checks++;
    if (lat !== LAT || result !== 64'd42 || result !== e) begin
      errors++;
      $display("FAIL after_flush_7x6: got result=%h lat=%0d expected %h lat=%0d", result, lat, 64'd42, LAT);
    end
    @(posedge clk); #1;
    // Flush in DONE beats the handshake.
    start_op(64'd2, 64'd3, 2'd0, 1'b0);
    wait_done(lat);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    void'(exp_q.pop_back());
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_done: got vld=%b rdy=%b busy=%b expected 0 1 0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    start_op(64'hDEAD_BEEF_0000_0001, 64'h55, 2'd1, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    void'(exp_q.pop_back());
    checks++;
    if ({in_ready, busy, out_valid} !== 3'b100 || result !== 64'd0) begin
      errors++;
      $display("FAIL reset_mid_busy: got rdy/busy/vld=%b result=%h expected 100 0",
               {in_ready, busy, out_valid}, result);
    end
  endtask

  task automatic test_random();
    int lat;
    logic [63:0] a, b, e;
    logic [63:0] pick[4];
    pick[0] = 64'hFFFF_FFFF_FFFF_FFFF; pick[1] = 64'h8000_0000_0000_0000;
    pick[2] = 64'h7FFF_FFFF_FFFF_FFFF; pick[3] = 64'd0;
    out_ready = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      a = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : {$urandom, $urandom};
      b = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : {$urandom, $urandom};
      start_op(a, b, 2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
      wait_done(lat);
      e = exp_q.pop_front();
      checks++;
      if (lat !== LAT || result !== e) begin
        errors++;
        $display("FAIL random_%0d: got result=%h lat=%0d expected result=%h lat=%0d",
                 n, result, lat, e, LAT);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    src1 = 64'd0; src2 = 64'd0; mul_op = 2'd0; is_word = 1'b0;
    repeat (3) begin @(posedge clk); end
    #1;
    test_reset();
    resetn = 1'b1;
    @(posedge clk); #1;
    test_mul_basic();
    test_corners();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
